// File: rtl/state_dumper.sv
// Post-run state dumper: sweeps the register file and then the data RAM over their
// read ports, and streams each word out as a tagged {src, idx, data} record on a valid/ready port.
module state_dumper #(
    parameter int DW        = 32,
    parameter int RF_DEPTH  = 32,
    parameter int RAM_WORDS = 64,
    parameter int IW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [4:0]    rf_raddr,
    input  logic [DW-1:0] rf_rdata,
    output logic [IW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_src,
    output logic [IW-1:0] out_idx,
    output logic [DW-1:0] out_data
);

    typedef enum logic [1:0] {IDLE, RF_SWEEP, RAM_SWEEP, DRAIN} state_t;

    state_t        state, state_d;
    logic [IW-1:0] counter, counter_d;
    logic          primed, primed_d;
    logic          out_valid_d, out_src_d, done_d;
    logic [IW-1:0] out_idx_d;
    logic [DW-1:0] out_data_d;
    logic          slot_free;

    assign slot_free = !out_valid || out_ready;
    assign busy      = (state != IDLE);
    assign rf_raddr  = (state == RF_SWEEP)  ? counter[4:0] : 5'd0;
    assign ram_raddr = (state == RAM_SWEEP) ? counter      : '0;

    always_comb begin
        // NOTE: every signal gets a default before the case, so no path leaves one unassigned (no latch).
        state_d     = state;
        counter_d   = counter;
        primed_d    = primed;
        out_valid_d = out_valid && !out_ready;
        out_src_d   = out_src;
        out_idx_d   = out_idx;
        out_data_d  = out_data;
        done_d      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d   = RF_SWEEP;
                    counter_d = '0;
                    primed_d  = 1'b0;
                end
            end
            RF_SWEEP: begin
                // First sweep cycle only presents address 0 so the RF read port, just handed
                // over from the halted CPU, settles before the first word is captured.
                primed_d = 1'b1;
                if (primed && slot_free) begin
                    out_valid_d = 1'b1;
                    out_src_d   = 1'b0;
                    out_idx_d   = counter;
                    out_data_d  = rf_rdata;
                    if (counter == IW'(RF_DEPTH - 1)) begin
                        counter_d = '0;
                        state_d   = RAM_SWEEP;
                    end else begin
                        counter_d = counter + IW'(1);
                    end
                end
            end
            RAM_SWEEP: begin
                if (slot_free) begin
                    out_valid_d = 1'b1;
                    out_src_d   = 1'b1;
                    out_idx_d   = counter;
                    out_data_d  = ram_rdata;
                    if (counter == IW'(RAM_WORDS - 1)) begin
                        counter_d = '0;
                        state_d   = DRAIN;
                    end else begin
                        counter_d = counter + IW'(1);
                    end
                end
            end
            DRAIN: begin
                if (out_valid && out_ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= '0;
            primed    <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_src   <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
        end else begin
            state     <= state_d;
            counter   <= counter_d;
            primed    <= primed_d;
            done      <= done_d;
            out_valid <= out_valid_d;
            out_src   <= out_src_d;
            out_idx   <= out_idx_d;
            out_data  <= out_data_d;
        end
    end

endmodule

// File: doc/state_dumper.md
Name: state_dumper

Overview:
- Read-side counterpart to the bench's memory-preload step, which writes instruction memory and register file contents.
- After a program run, this block sweeps the CPU register file, then the data RAM, over their read ports.
- It streams every word out as a tagged record on a valid/ready interface, for host capture or self-check comparison.
- It sits beside CPU, shares RF/RAM read ports while the CPU is halted, and does not write any state.

Parameters:
- DW, 32, data word width.
- RF_DEPTH, 32, registers swept (indices 0..RF_DEPTH-1).
- RAM_WORDS, 64, data RAM words swept (word indices 0..RAM_WORDS-1).
- IW, 8, index width of out_idx; must hold max(RF_DEPTH, RAM_WORDS)-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse in IDLE begins a dump; ignored otherwise.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final record handshakes.
- rf_raddr  out  5  RF read address; RF read is combinational, same cycle.
- rf_rdata  in  DW  RF read data.
- ram_raddr  out  IW  RAM word address; RAM read is combinational, same cycle.
- ram_rdata  in  DW  RAM read data.
- out_valid  out  1  record available.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- out_src  out  1  0 = register file, 1 = data RAM.
- out_idx  out  IW  register number or RAM word index.
- out_data  out  DW  captured word.

Behaviour:
- Reset (async, immediate):
  - state = IDLE, counter = 0.
  - busy = 0, done = 0, out_valid = 0, out_src = 0, out_idx = 0, out_data = 0.
  - rf_raddr = 0, ram_raddr = 0.
- States: IDLE, RF_SWEEP, RAM_SWEEP, DRAIN.
- IDLE:
  - start = 1 -> RF_SWEEP, counter = 0, busy = 1 at next edge.
- Output stage: a single register. "slot_free" = !out_valid || out_ready.
- RF_SWEEP:
  - rf_raddr = counter.
  - If slot_free: capture {0, counter, rf_rdata} into the output register, out_valid = 1, counter++.
  - When capturing counter = RF_DEPTH-1: counter = 0, -> RAM_SWEEP.
  - If !slot_free: hold counter and the output register; no read side effects.
- RAM_SWEEP:
  - Same rules with ram_raddr = counter, out_src = 1.
  - Capturing counter = RAM_WORDS-1 -> DRAIN.
- DRAIN:
  - On the handshake of the last record: out_valid = 0, done = 1 for one cycle, busy = 0, -> IDLE.
- Output register outside a capture:
  - If out_ready && out_valid with no new capture, out_valid falls to 0.
  - out_src/out_idx/out_data hold stable while out_valid && !out_ready (AXI-style: no change until accepted).
- Throughput and latency:
  - With out_ready held 1, one record per cycle.
  - First out_valid rises 2 edges after the edge sampling start.
  - Total records = RF_DEPTH + RAM_WORDS, in order RF 0..RF_DEPTH-1, then RAM 0..RAM_WORDS-1.
  - done pulses on the edge after the last transfer.
- rf_raddr/ram_raddr outside their own sweep state: drive 0.
- start while busy or in DRAIN: ignored, no restart.
- Register 0 is dumped like any other; its value comes from RF (always 0).
- out_ready toggling arbitrarily: no record lost or duplicated; indices strictly sequential.
- rst mid-dump: immediate return to IDLE, output dropped. A new start restarts from RF index 0.

Test Plan:
- Preload RF[i] = i*16'h0101, RAM[j] = 32'hA000_0000+j; start with out_ready = 1 -> 96 records, first at start+2 cycles, last at start+97; done pulse at start+98; every record matches its tag/index.
- out_ready low for 5 cycles while out_valid = 1 on RF index 7 -> out_idx/out_data frozen at 7/RF[7]; rf_raddr held at 8; resumes at 8 with no gap or duplicate.
- out_ready pseudo-random 50% -> exactly 32 RF then 64 RAM records, indices gapless, sum of out_data equals the preloaded sum.
- start pulsed again at RAM index 10 -> ignored; sequence and done timing unchanged; busy stays 1.
- rst asserted during RAM index 20 -> out_valid/busy/done drop asynchronously to 0; a new start begins at RF index 0 with out_src = 0.
- RF index 0 record -> out_src = 0, out_idx = 0, out_data = 0; crossing to RAM: RF 31 immediately followed by RAM 0 with no bubble when out_ready = 1.
